// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Word-addressed data memory behind a simple request/response handshake.
// It accepts one request at a time, optionally waits a programmable number
// of cycles, then presents a single registered response until it is taken.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1; a response transfers on a rising edge where resp_valid=1 and
// resp_ready=1. Once resp_valid is raised, resp_rdata and resp_err stay
// stable until that transfer. req_ready is high only while idle, so a new
// request is never taken on the edge that completes a response.
//
// Optional feature: define DATA_MEM_WAIT_STATE_EN to insert WAIT_CYCLES wait
// states between accept and response. Left undefined, the response follows
// the accept edge by one cycle and there is no WAIT state or counter.
//
// Parameters:
//   DEPTH        number of 32-bit storage words
//   WAIT_CYCLES  wait states per access (0..255), used only with the macro
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   req_valid    request present
//   req_we       1 = write, 0 = read
//   req_addr     byte address (word index is req_addr[31:2])
//   req_wdata    write data
//   req_ready    responder is idle and can accept
//   resp_valid   response present
//   resp_rdata   read data (0 for writes and errors)
//   resp_err     misaligned or out-of-range access
//   resp_ready   initiator takes the response
//   dbg_state    current FSM state encoding (0 idle, 1 wait, 2 resp)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WAIT_CYCLES > 255) begin : g_bad_wait_cycles
        $error("data_mem_responder: WAIT_CYCLES must be in 0..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef DATA_MEM_WAIT_STATE_EN
        ST_WAIT = 2'd1,
`endif
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    // Request captured at the accept edge.
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

`ifdef DATA_MEM_WAIT_STATE_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    // Storage is deliberately left out of reset.
    logic [31:0] mem [DEPTH];

    // The access happens on the edge entering RESP. Coming straight from
    // IDLE that is the accept edge itself, so the live request is used;
    // coming from WAIT the captured copy is used.
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          enter_resp;
    logic          mem_we;

    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_idx = acc_addr[AW+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) ||
                  ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
`ifdef DATA_MEM_WAIT_STATE_EN
        cnt_d        = cnt_q;
`endif
        enter_resp   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
`ifdef DATA_MEM_WAIT_STATE_EN
                    if (WAIT_CYCLES >= 1) begin
                        // Counter runs WAIT_CYCLES-1 down to 0, one WAIT
                        // cycle per count value.
                        state_d     = ST_WAIT;
                        req_ready_d = 1'b0;
                        cnt_d       = 8'(WAIT_CYCLES - 1);
                    end else begin
                        enter_resp = 1'b1;
                    end
`else
                    enter_resp = 1'b1;
`endif
                end
            end
`ifdef DATA_MEM_WAIT_STATE_EN
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        if (enter_resp) begin
            state_d      = ST_RESP;
            req_ready_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = acc_err;
            if (acc_err || acc_we) begin
                resp_rdata_d = 32'h0;
            end else begin
                resp_rdata_d = mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
`ifdef DATA_MEM_WAIT_STATE_EN
            cnt_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef DATA_MEM_WAIT_STATE_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Gated by rst so a request presented while reset is held never writes.
    assign mem_we = enter_resp && acc_we && !acc_err;

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Drives data_mem_responder (DEPTH=256, WAIT_CYCLES=3) with directed and
// random transactions and compares every response against a plain array
// model of the storage. A second instance with WAIT_CYCLES=0 checks that
// zero wait states give the one-cycle latency. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 3;
`ifdef DATA_MEM_WAIT_STATE_EN
    localparam int LAT = WAIT_CYCLES + 1;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main DUT ----------------
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_ready(resp_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- zero-wait DUT ----------------
    logic        rst0 = 1'b1;
    logic        d0_req_valid = 1'b0, d0_req_we = 1'b0, d0_resp_ready = 1'b0;
    logic [31:0] d0_req_addr = '0, d0_req_wdata = '0;
    logic        d0_req_ready, d0_resp_valid, d0_resp_err;
    logic [31:0] d0_resp_rdata;
    logic [1:0]  d0_dbg_state;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst0),
        .req_valid(d0_req_valid), .req_we(d0_req_we), .req_addr(d0_req_addr),
        .req_wdata(d0_req_wdata), .req_ready(d0_req_ready),
        .resp_valid(d0_resp_valid), .resp_rdata(d0_resp_rdata),
        .resp_err(d0_resp_err), .resp_ready(d0_resp_ready),
        .dbg_state(d0_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] ref_mem [DEPTH];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (int'(a[31:2]) >= DEPTH) || (a[31] == 1'b1);
    endfunction

    task automatic junk_or_idle(input bit junk);
        if (junk) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    // One complete transaction on the main DUT with bp cycles of backpressure.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int bp, input bit junk);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          lat;
        exp_err   = addr_bad(addr);
        exp_rdata = 32'h0;
        if (!exp_err && !we) exp_rdata = ref_mem[addr[31:2]];

        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            junk_or_idle(junk);
            if (resp_valid === 1'b1 || lat > LAT + 8) break;
            check("req_ready_busy", {31'b0, req_ready}, 32'd0);
        end
        check("latency", lat, LAT);
        if (resp_valid !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        for (int i = 0; i <= bp; i++) begin
            if (i > 0) begin
                @(negedge clk);
                junk_or_idle(junk);
            end
            check("resp_valid_hold", {31'b0, resp_valid}, 32'd1);
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
            check("req_ready_resp", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check("resp_done_valid", {31'b0, resp_valid}, 32'd0);
        check("resp_done_ready", {31'b0, req_ready}, 32'd1);
        check("resp_done_state", {30'b0, dbg_state}, 32'd0);
        if (!exp_err && we) ref_mem[addr[31:2]] = wdata;
    endtask

    // Zero-wait instance: response must be valid one cycle after accept.
    task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        d0_req_valid  = 1'b1;
        d0_req_we     = we;
        d0_req_addr   = addr;
        d0_req_wdata  = wdata;
        d0_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d0_req_valid = 1'b0;
        check("d0_resp_valid", {31'b0, d0_resp_valid}, 32'd1);
        check("d0_resp_rdata", d0_resp_rdata, exp_rdata);
        check("d0_resp_err", {31'b0, d0_resp_err}, {31'b0, exp_err});
        @(negedge clk);
        check("d0_done_valid", {31'b0, d0_resp_valid}, 32'd0);
        check("d0_done_ready", {31'b0, d0_req_ready}, 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] a;
        logic        rst_we;
        int          sel;

        // Reset state, asynchronous assertion before any clock edge.
        #2 rst = 1'b0; rst0 = 1'b0;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; rst0 = 1'b1;

        // Give every word a known value so the model is fully defined.
        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i) << 2, $urandom, 0, 1'b0);

        // Write then read-back at 0x10.
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0);
        txn(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);

        // Error cases; word 1 must survive the misaligned write.
        txn(1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 0, 1'b0);
        txn(1'b0, 32'h0000_0400, 32'h0, 0, 1'b0);
        txn(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0);
        txn(1'b0, 32'h0000_03FC, 32'h0, 0, 1'b0);

        // Backpressure with request inputs toggling while busy.
        txn(1'b0, 32'h0000_0010, 32'h0, 5, 1'b1);
        txn(1'b1, 32'h0000_0008, 32'h5A5A_A5A5, 5, 1'b1);
        txn(1'b0, 32'h0000_0008, 32'h0, 2, 1'b1);

        // Reset in the middle of an access. With wait states this lands in
        // WAIT during a write, which must then leave storage untouched.
`ifdef DATA_MEM_WAIT_STATE_EN
        rst_we = 1'b1;
`else
        rst_we = 1'b0;
`endif
        @(negedge clk);
        req_valid = 1'b1; req_we = rst_we; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_resp_err", {31'b0, resp_err}, 32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'h0);
        check("midrst_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 32'h0000_0020, 32'h0, 0, 1'b0);

        // Random traffic: mostly legal, some misaligned, some out of range.
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
            else               a = 32'($urandom_range(DEPTH, 4095)) << 2;
            txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Zero wait states: one-cycle latency, coherent read-back, errors.
        txn0(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0);
        txn0(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1'b0);
        txn0(1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1);
        txn0(1'b1, 32'h0000_0013, 32'h1111_2222, 32'h0, 1'b1);
        txn0(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
